// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with flush/freeze handling, bubble tracking and a freeze watchdog.
// Optional performance counters are enabled by defining ID_EXE_PERF_EN.
module id_exe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 4,
  parameter int CMD_W      = 4,
  parameter int MAX_FREEZE = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_val_rn,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic              in_imm,
  input  logic [11:0]       in_shift_operand,
  input  logic [23:0]       in_signed_imm24,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [REG_W-1:0]  in_src1,
  input  logic [REG_W-1:0]  in_src2,
  input  logic              in_two_src,
  input  logic [CMD_W-1:0]  in_exe_cmd,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic              in_b,
  input  logic              in_s,
  input  logic              in_carry,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_val_rn,
  output logic [DATA_W-1:0] out_val_rm,
  output logic              out_imm,
  output logic [11:0]       out_shift_operand,
  output logic [23:0]       out_signed_imm24,
  output logic [REG_W-1:0]  out_dest,
  output logic [REG_W-1:0]  out_src1,
  output logic [REG_W-1:0]  out_src2,
  output logic              out_two_src,
  output logic [CMD_W-1:0]  out_exe_cmd,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic              out_b,
  output logic              out_s,
  output logic              out_carry,
`ifdef ID_EXE_PERF_EN
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_freeze_cnt,
`endif
  output logic              freeze_timeout
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm24;
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic              two_src;
    logic [CMD_W-1:0]  exe_cmd;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
    logic              carry;
  } stage_t;

  localparam logic [7:0] FREEZE_LIMIT = 8'(MAX_FREEZE);

  stage_t     stage_d, stage_q;
  logic [7:0] frz_cnt_d, frz_cnt_q;
  logic       timeout_d, timeout_q;
  logic       hold;
  logic       load_bubble;

  assign hold        = freeze & ~flush;
  assign load_bubble = flush | (~freeze & ~in_valid);

  // Bubbles are all-zero so downstream control bits can never fire on them.
  always_comb begin
    stage_d = stage_q;
    if (load_bubble) begin
      stage_d = '0;
    end else if (!freeze) begin
      stage_d.valid         = 1'b1;
      stage_d.pc            = in_pc;
      stage_d.val_rn        = in_val_rn;
      stage_d.val_rm        = in_val_rm;
      stage_d.imm           = in_imm;
      stage_d.shift_operand = in_shift_operand;
      stage_d.signed_imm24  = in_signed_imm24;
      stage_d.dest          = in_dest;
      stage_d.src1          = in_src1;
      stage_d.src2          = in_src2;
      stage_d.two_src       = in_two_src;
      stage_d.exe_cmd       = in_exe_cmd;
      stage_d.wb_en         = in_wb_en;
      stage_d.mem_r_en      = in_mem_r_en;
      stage_d.mem_w_en      = in_mem_w_en;
      stage_d.b             = in_b;
      stage_d.s             = in_s;
      stage_d.carry         = in_carry;
    end
  end

  always_comb begin
    frz_cnt_d = 8'd0;
    if (hold) begin
      frz_cnt_d = (frz_cnt_q == FREEZE_LIMIT) ? frz_cnt_q : frz_cnt_q + 8'd1;
    end
    timeout_d = (frz_cnt_d == FREEZE_LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q   <= '0;
      frz_cnt_q <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      frz_cnt_q <= frz_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_valid         = stage_q.valid;
  assign out_pc            = stage_q.pc;
  assign out_val_rn        = stage_q.val_rn;
  assign out_val_rm        = stage_q.val_rm;
  assign out_imm           = stage_q.imm;
  assign out_shift_operand = stage_q.shift_operand;
  assign out_signed_imm24  = stage_q.signed_imm24;
  assign out_dest          = stage_q.dest;
  assign out_src1          = stage_q.src1;
  assign out_src2          = stage_q.src2;
  assign out_two_src       = stage_q.two_src;
  assign out_exe_cmd       = stage_q.exe_cmd;
  assign out_wb_en         = stage_q.wb_en;
  assign out_mem_r_en      = stage_q.mem_r_en;
  assign out_mem_w_en      = stage_q.mem_w_en;
  assign out_b             = stage_q.b;
  assign out_s             = stage_q.s;
  assign out_carry         = stage_q.carry;
  assign freeze_timeout    = timeout_q;

`ifdef ID_EXE_PERF_EN
  logic [31:0] bub_cnt_d, bub_cnt_q;
  logic [31:0] pfrz_cnt_d, pfrz_cnt_q;

  // Both counters saturate rather than wrap.
  always_comb begin
    bub_cnt_d  = bub_cnt_q;
    pfrz_cnt_d = pfrz_cnt_q;
    if (load_bubble && bub_cnt_q != 32'hFFFF_FFFF) bub_cnt_d = bub_cnt_q + 32'd1;
    if (hold && pfrz_cnt_q != 32'hFFFF_FFFF) pfrz_cnt_d = pfrz_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bub_cnt_q  <= 32'd0;
      pfrz_cnt_q <= 32'd0;
    end else begin
      bub_cnt_q  <= bub_cnt_d;
      pfrz_cnt_q <= pfrz_cnt_d;
    end
  end

  assign perf_bubble_cnt = bub_cnt_q;
  assign perf_freeze_cnt = pfrz_cnt_q;
`endif

endmodule
